mant_norm_round: RTL and testbench
==================================

# mant_norm_round

Normalize/round/pack stage of the multiply-add datapath. Consumes the significand product emitted by the Booth/Wallace multiplier stage, plus the sign and pre-computed exponent, and produces a packed IEEE-754 result. Single precision when `con`=1, half precision when `con`=0. Three-stage pipeline with valid/ready flow control.

## Interface
- No parameters; widths fixed by the multiplier: 64-bit product, 10-bit exponent.
- `clk`  in  1  — single clock, rising edge
- `rst`  in  1  — asynchronous, active-low reset
- `valid_in`  in  1  — input beat present
- `in_ready`  out  1  — stage 1 can accept
- `P`  in  64  — unsigned significand product; single: `P[47:0]` valid (24b×24b); half: `P[21:0]` valid (11b×11b); upper bits ignored
- `exp_in`  in  10  — signed biased exponent: ea+eb−bias, referenced to a leading one at bit 46 (single) or bit 20 (half)
- `sign_in`  in  1  — result sign
- `con`  in  1  — 1 = single, 0 = half
- `error`  in  1  — upstream invalid-operand flag
- `out_valid`  out  1  — result beat present
- `out_ready`  in  1  — consumer accepts
- `res`  out  32  — single `{s,e8,f23}`; half `{16'b0,s,e5,f10}`
- `ovf`, `unf`, `inx`, `err_out`  out  1 each — overflow, underflow (flush), inexact, invalid

## Operation
- Stage 1 (normalize): map the product to N[47:0]; half aligns `P[21:0]` to `N[47:26]`. If the top bit is set, N=P and e=exp_in+1; otherwise N=P<<1 and e=exp_in. Zero-detect on the valid product field.
- Stage 2 (round, RNE): frac=N[46:24] (single) or N[46:37] (half); guard is the next bit; sticky is the OR of the rest. Round up when guard & (sticky | frac lsb). A carry out of frac gives frac=0 and e+1. inx = guard | sticky.
- Stage 3 (range/pack), in priority order:
  - error → quiet NaN: 0x7FC00000 / 0x00007E00, err_out=1, other flags 0.
  - zero product → signed zero, no flags.
  - e ≥ 255 (single) / ≥ 31 (half) → signed infinity, ovf=1, inx=1.
  - e ≤ 0 → signed zero flush, unf=1, inx=1.
  - otherwise pack e[7:0]/e[4:0] with frac.
- `con`, `sign_in` and `error` travel with the data through every stage; no cross-beat state.

## Timing
- Latency 3 cycles from an accepted beat (valid_in & in_ready) to out_valid.
- Throughput 1/cycle. The pipe advances when !out_valid | out_ready. in_ready = that same advance term (combinational from out_ready).
- Stall: all stage registers hold; `res` and flags stay stable while out_valid & !out_ready.
- Bubbles propagate as invalid; data registers of invalid stages are don't-care, but outputs are zeroed when out_valid=0.
- Reset (also mid-operation): all stage valids 0, res=0, flags 0, out_valid=0. In-flight beats are discarded. in_ready=1 once out of reset.

## Structure
- Shared package `maf_pkg`: format constants (EXP_MAX_SP=255, EXP_MAX_HP=31, QNAN_SP, QNAN_HP, frac widths), and the stage payload struct {N, e, sign, con, err, zero, guard, sticky}.
- Sub-module `rne_round`: combinational frac/guard/sticky → rounded frac + carry + inexact, used by stage 2 with `con`-selected fields.

## Test plan
- Single 1.0×1.0: P=2^46, exp_in=127, sign 0 → res=0x3F800000, no flags, out_valid exactly 3 cycles after acceptance.
- Single 1.5×1.5: P=0x900000000000, exp_in=127 → res=0x40100000. Half 1.0×1.0: P=2^20, exp_in=15, con=0 → res=0x00003C00.
- RNE ties: P=2^46+2^22 → 0x3F800000, inx=1; P=2^46+2^23+2^22 → 0x3F800002, inx=1.
- Range cases:
  - exp_in=255, P=2^46, sign 1 → 0xFF800000, ovf=inx=1.
  - exp_in=0, P=2^46 → 0x00000000, unf=inx=1.
  - error=1 → 0x7FC00000, err_out=1.
- Backpressure: stream of 6 beats with out_ready held low for 4 cycles mid-stream → no loss or duplication, in-order results, res stable while stalled.
- Assert rst low with 3 beats in flight → out_valid=0 and res=0 immediately. After release, the next beat completes normally with 3-cycle latency.

Source files
------------

// File: rtl/maf_pkg.sv
// maf_pkg: shared format constants and stage payloads for the multiply-add back end.
// Exponents are carried as 11-bit two's complement so exp_in+2 cannot wrap.
// Payload structs are the per-stage register contents of mant_norm_round.
package maf_pkg;

  localparam int FRAC_SP = 23;
  localparam int FRAC_HP = 10;
  localparam int EXP_W   = 11;

  localparam logic [EXP_W-1:0] EXP_MAX_SP = 11'd255;
  localparam logic [EXP_W-1:0] EXP_MAX_HP = 11'd31;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
  localparam logic [31:0] QNAN_HP = 32'h0000_7E00;

  // Normalized product: leading one sits at n[47] unless the product is zero.
  typedef struct packed {
    logic [47:0]      n;
    logic [EXP_W-1:0] e;
    logic             sign;
    logic             con;
    logic             err;
    logic             zero;
    logic             guard;
    logic             sticky;
  } norm_t;

  // Rounded significand; half results live in frac[9:0].
  typedef struct packed {
    logic [FRAC_SP-1:0] frac;
    logic [EXP_W-1:0]   e;
    logic               sign;
    logic               con;
    logic               err;
    logic               zero;
    logic               inx;
  } rnd_t;

endpackage

// File: rtl/rne_round.sv
// rne_round: round-to-nearest-even of a W-bit fraction given guard and sticky.
// Latency 0 (combinational).
// No flow control; carry_o flags a fraction wrap that bumps the exponent.
module rne_round #(
  parameter int W = 23
) (
  input  logic [W-1:0] frac_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  output logic [W-1:0] frac_o,
  output logic         carry_o,
  output logic         inx_o
);

  logic         rnd_up;
  logic [W:0]   sum;

  // Ties go to the even fraction: only round up on a tie when the lsb is odd.
  assign rnd_up  = guard_i & (sticky_i | frac_i[0]);
  assign sum     = {1'b0, frac_i} + {{W{1'b0}}, rnd_up};
  assign frac_o  = sum[W-1:0];
  assign carry_o = sum[W];
  assign inx_o   = guard_i | sticky_i;

endmodule

// File: rtl/mant_norm_round.sv
// mant_norm_round: normalize, RNE-round and pack a significand product to SP (con=1) or HP.
// Latency 3 cycles from an accepted beat to out_valid, throughput 1 beat/cycle.
// Backpressure: all stages hold while out_valid & !out_ready; in_ready is that advance term.
module mant_norm_round
  import maf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        in_ready,
  input  logic [63:0] P,
  input  logic [9:0]  exp_in,
  input  logic        sign_in,
  input  logic        con,
  input  logic        error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        ovf,
  output logic        unf,
  output logic        inx,
  output logic        err_out
);

  logic        adv;
  logic        s1_vld_q, s2_vld_q, out_vld_q;
  norm_t       s1_d, s1_q;
  rnd_t        s2_d, s2_q;
  logic [31:0] res_d, res_q;
  logic        ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q, err_d, err_q;
  logic [47:0] pf;
  logic [10:0] exp_ext;

  logic [FRAC_SP-1:0] sp_frac;
  logic [FRAC_HP-1:0] hp_frac;
  logic               sp_carry, hp_carry, sp_inx, hp_inx;
  logic [10:0]        emax;

  // Bits that never reach a result: upper product bits and the hidden/low normalized bits.
  logic unused_bits;
  assign unused_bits = ^{P[63:48], s1_q.n[47], s1_q.n[23:0]};

  assign adv       = !out_vld_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_vld_q;
  assign res       = res_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign inx       = inx_q;
  assign err_out   = err_q;

  assign pf      = con ? P[47:0] : {P[21:0], 26'b0};
  assign exp_ext = {exp_in[9], exp_in};

  // Stage 1: align the product so the leading one lands on bit 47, and collect guard/sticky.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = sign_in;
    s1_d.con  = con;
    s1_d.err  = error;
    s1_d.zero = (pf == 48'b0);
    if (pf[47]) begin
      s1_d.n = pf;
      s1_d.e = exp_ext + 11'd1;
    end else begin
      s1_d.n = pf << 1;
      s1_d.e = exp_ext;
    end
    s1_d.guard  = con ? s1_d.n[23] : s1_d.n[36];
    s1_d.sticky = con ? |s1_d.n[22:0] : |s1_d.n[35:0];
  end

  rne_round #(.W(FRAC_SP)) u_rnd_sp (
    .frac_i   (s1_q.n[46:24]),
    .guard_i  (s1_q.guard),
    .sticky_i (s1_q.sticky),
    .frac_o   (sp_frac),
    .carry_o  (sp_carry),
    .inx_o    (sp_inx)
  );

  rne_round #(.W(FRAC_HP)) u_rnd_hp (
    .frac_i   (s1_q.n[46:37]),
    .guard_i  (s1_q.guard),
    .sticky_i (s1_q.sticky),
    .frac_o   (hp_frac),
    .carry_o  (hp_carry),
    .inx_o    (hp_inx)
  );

  // Stage 2: pick the rounded fraction for the format and fold a rounding carry into e.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.con  = s1_q.con;
    s2_d.err  = s1_q.err;
    s2_d.zero = s1_q.zero;
    if (s1_q.con) begin
      s2_d.frac = sp_frac;
      s2_d.e    = s1_q.e + {10'b0, sp_carry};
      s2_d.inx  = sp_inx;
    end else begin
      s2_d.frac = {{(FRAC_SP-FRAC_HP){1'b0}}, hp_frac};
      s2_d.e    = s1_q.e + {10'b0, hp_carry};
      s2_d.inx  = hp_inx;
    end
  end

  assign emax = s2_q.con ? EXP_MAX_SP : EXP_MAX_HP;

  // Stage 3: special cases in priority order, then pack; a bubble yields all-zero outputs.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    err_d = 1'b0;
    if (s2_vld_q) begin
      if (s2_q.err) begin
        res_d = s2_q.con ? QNAN_SP : QNAN_HP;
        err_d = 1'b1;
      end else if (s2_q.zero) begin
        res_d = s2_q.con ? {s2_q.sign, 31'b0} : {16'b0, s2_q.sign, 15'b0};
      end else if ($signed(s2_q.e) >= $signed(emax)) begin
        res_d = s2_q.con ? {s2_q.sign, 8'hFF, 23'b0} : {16'b0, s2_q.sign, 5'h1F, 10'b0};
        ovf_d = 1'b1;
        inx_d = 1'b1;
      end else if ($signed(s2_q.e) <= $signed(11'd0)) begin
        res_d = s2_q.con ? {s2_q.sign, 31'b0} : {16'b0, s2_q.sign, 15'b0};
        unf_d = 1'b1;
        inx_d = 1'b1;
      end else begin
        res_d = s2_q.con ? {s2_q.sign, s2_q.e[7:0], s2_q.frac}
                         : {16'b0, s2_q.sign, s2_q.e[4:0], s2_q.frac[9:0]};
        inx_d = s2_q.inx;
      end
    end
  end

  // All three stages advance together whenever the output slot is empty or being drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inx_q     <= 1'b0;
      err_q     <= 1'b0;
    end else if (adv) begin
      s1_vld_q  <= valid_in;
      s1_q      <= s1_d;
      s2_vld_q  <= s1_vld_q;
      s2_q      <= s2_d;
      out_vld_q <= s2_vld_q;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      inx_q     <= inx_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mant_norm_round.sv
// tb_mant_norm_round: vector table driven through a scoreboard queue for mant_norm_round.
// Checks results, flags, 3-cycle latency, stall stability, idle zeroing and mid-flight reset.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_mant_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, in_ready;
  logic [63:0] P;
  logic [9:0]  exp_in;
  logic        sign_in, con, error;
  logic        out_valid, out_ready;
  logic [31:0] res;
  logic        ovf, unf, inx, err_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mant_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .P         (P),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .con       (con),
    .error     (error),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf),
    .unf       (unf),
    .inx       (inx),
    .err_out   (err_out)
  );

  // flags are {ovf, unf, inx, err_out}
  typedef struct {
    logic [63:0] p;
    logic [9:0]  e;
    logic        s;
    logic        c;
    logic        err;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
    bit          lat;
  } sb_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  sb_t  sb[$];

  logic [31:0] cur_res;
  logic [3:0]  cur_fl;
  bit          cur_lat;
  logic [31:0] prev_res;
  logic [3:0]  prev_fl;
  bit          prev_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pop/compare on output handshakes, push on input handshakes.
  always @(negedge clk) begin
    logic [3:0] fl;
    sb_t        ex;
    fl = {ovf, unf, inx, err_out};
    if (rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got res %h, required no beat", res);
        end else begin
          ex = sb.pop_front();
          chk("res", res, ex.res);
          chk("flags", {28'b0, fl}, {28'b0, ex.fl});
          if (ex.lat) chk("latency", 32'(cyc - ex.cyc), 32'd3);
        end
      end
      if (!out_valid) begin
        chk("idle_res", res, 32'd0);
        chk("idle_flags", {28'b0, fl}, 32'd0);
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          chk("stall_res", res, prev_res);
          chk("stall_flags", {28'b0, fl}, {28'b0, prev_fl});
        end
        prev_stall = 1'b1;
        prev_res   = res;
        prev_fl    = fl;
      end else begin
        prev_stall = 1'b0;
      end
      if (valid_in && in_ready)
        sb.push_back('{res: cur_res, fl: cur_fl, cyc: cyc, lat: cur_lat});
    end
  end

  // Present vector i until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input int i, input bit lat);
    bit acc;
    int n;
    P        = vecs[i].p;
    exp_in   = vecs[i].e;
    sign_in  = vecs[i].s;
    con      = vecs[i].c;
    error    = vecs[i].err;
    cur_res  = vecs[i].res;
    cur_fl   = vecs[i].fl;
    cur_lat  = lat;
    valid_in = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    valid_in = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: vector %0d not accepted after %0d cycles, required acceptance", i, n);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            P                        exp      s  c  err  res            flags
    vecs[0]  = '{64'h0000_4000_0000_0000, 10'd127, 0, 1, 0, 32'h3F80_0000, 4'b0000};
    vecs[1]  = '{64'h0000_9000_0000_0000, 10'd127, 0, 1, 0, 32'h4010_0000, 4'b0000};
    vecs[2]  = '{64'h0000_0000_0010_0000, 10'd15,  0, 0, 0, 32'h0000_3C00, 4'b0000};
    vecs[3]  = '{64'h0000_4000_0040_0000, 10'd127, 0, 1, 0, 32'h3F80_0000, 4'b0010};
    vecs[4]  = '{64'h0000_4000_00C0_0000, 10'd127, 0, 1, 0, 32'h3F80_0002, 4'b0010};
    vecs[5]  = '{64'h0000_4000_0000_0000, 10'd255, 1, 1, 0, 32'hFF80_0000, 4'b1010};
    vecs[6]  = '{64'h0000_4000_0000_0000, 10'd0,   0, 1, 0, 32'h0000_0000, 4'b0110};
    vecs[7]  = '{64'h0000_4000_0000_0000, 10'd127, 0, 1, 1, 32'h7FC0_0000, 4'b0001};
    vecs[8]  = '{64'h0000_0000_0010_0000, 10'd15,  0, 0, 1, 32'h0000_7E00, 4'b0001};
    vecs[9]  = '{64'h0000_0000_0000_0000, 10'd100, 1, 1, 0, 32'h8000_0000, 4'b0000};
    vecs[10] = '{64'h0000_0000_0010_0000, 10'd15,  1, 0, 0, 32'h0000_BC00, 4'b0000};
    vecs[11] = '{64'h0000_FFFF_FF80_0000, 10'd126, 0, 1, 0, 32'h4000_0000, 4'b0010};
    vecs[12] = '{64'h0000_0000_0010_0000, 10'd31,  0, 0, 0, 32'h0000_7C00, 4'b1010};
    vecs[13] = '{64'hFFFF_4000_0000_0000, 10'd127, 0, 1, 0, 32'h3F80_0000, 4'b0000};
    vecs[14] = '{64'h0000_0000_0010_0600, 10'd15,  0, 0, 0, 32'h0000_3C02, 4'b0010};
    vecs[15] = '{64'h0000_4000_0000_0000, 10'h3FB, 1, 1, 0, 32'h8000_0000, 4'b0110};
    vecs[16] = '{64'h0000_4000_0000_0000, 10'd254, 0, 1, 0, 32'h7F00_0000, 4'b0000};
    vecs[17] = '{64'h0000_4000_0000_0000, 10'd1,   0, 1, 0, 32'h0080_0000, 4'b0000};
    vecs[18] = '{64'hFFFF_FFFF_FFD0_0000, 10'd15,  0, 0, 0, 32'h0000_3C00, 4'b0000};

    rst       = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b1;
    P         = '0;
    exp_in    = '0;
    sign_in   = 1'b0;
    con       = 1'b1;
    error     = 1'b0;
    cur_res   = '0;
    cur_fl    = '0;
    cur_lat   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_flags", {28'b0, ovf, unf, inx, err_out}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Back-to-back table sweep at full throughput, latency checked on every beat.
    for (int i = 0; i < NV; i++) send(i, 1'b1);
    drain("drain_table");

    // Six-beat stream with the consumer stalling for four cycles mid-stream.
    fork
      begin
        for (int k = 0; k < 6; k++) send(k, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset with three beats in flight: everything discarded, outputs cleared at once.
    send(0, 1'b0);
    send(1, 1'b0);
    send(2, 1'b0);
    chk("inflight_before_reset", {31'b0, out_valid}, 32'd1);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_res", res, 32'd0);
    chk("midreset_flags", {28'b0, ovf, unf, inx, err_out}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(4, 1'b1);
    drain("drain_after_reset");

    repeat (5) @(posedge clk);
    #1;
    chk("no_stray_beats", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
